reorder_buffer: RTL

In-order commit buffer between the execute/memory stages and `regFile`. Decode allocates one entry per issued instruction. Functional units report completion out of order, tagged with the entry id. The block retires the oldest completed entry each cycle by driving the `regFile` write port or its exception port. When an exception commits, every younger entry is flushed.

---
 rtl/reorder_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order commit buffer: decode allocates at the tail, functional units complete out of order,
// the oldest completed entry retires to the regFile write or exception port each cycle.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef REG_FILE_ADDR_RANGE
`define REG_FILE_ADDR_RANGE 4:0
`endif
`ifndef REG_FILE_DATA_RANGE
`define REG_FILE_DATA_RANGE 31:0
`endif
`ifndef REG_FILE_XCPT_ADDR_RANGE
`define REG_FILE_XCPT_ADDR_RANGE 31:0
`endif

package reorder_buffer_pkg;
  typedef logic [3:0] xcpt_type_t;
endpackage

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_ENTRIES  = 8,
  parameter int unsigned ROB_ID_WIDTH = $clog2(ROB_ENTRIES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [ROB_ID_WIDTH-1:0]          alloc_id,
  input  logic [`PC_WIDTH-1:0]             alloc_pc,
  input  logic                             alloc_has_dest,
  input  logic [`REG_FILE_ADDR_RANGE]      alloc_dest_addr,
  input  logic                             alloc_iret,
  input  logic                             cmpl_valid,
  input  logic [ROB_ID_WIDTH-1:0]          cmpl_id,
  input  logic [`REG_FILE_DATA_RANGE]      cmpl_value,
  input  logic                             cmpl_xcpt_valid,
  input  xcpt_type_t                       cmpl_xcpt_type,
  input  logic [`REG_FILE_XCPT_ADDR_RANGE] cmpl_xcpt_addr,
  output logic                             writeEn,
  output logic [`REG_FILE_ADDR_RANGE]      dest_addr,
  output logic [`REG_FILE_DATA_RANGE]      writeVal,
  output logic                             xcpt_valid,
  output xcpt_type_t                       xcpt_type,
  output logic [`PC_WIDTH-1:0]             rmPC,
  output logic [`REG_FILE_XCPT_ADDR_RANGE] rmAddr,
  output logic                             iret_instr,
  output logic                             flush,
  output logic                             empty
);

  localparam int unsigned CNT_W = ROB_ID_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_ENTRIES);

  logic [ROB_ENTRIES-1:0]          valid_q, valid_d;
  logic [ROB_ENTRIES-1:0]          done_q, done_d;
  logic [ROB_ENTRIES-1:0]          has_dest_q, iret_q, xcpt_q;
  logic [`PC_WIDTH-1:0]            pc_q    [ROB_ENTRIES];
  logic [`REG_FILE_ADDR_RANGE]     dest_q  [ROB_ENTRIES];
  logic [`REG_FILE_DATA_RANGE]     value_q [ROB_ENTRIES];
  xcpt_type_t                      xtype_q [ROB_ENTRIES];
  logic [`REG_FILE_XCPT_ADDR_RANGE] xaddr_q [ROB_ENTRIES];

  logic [ROB_ID_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic commit, commit_ok, commit_xcpt, alloc_fire, cmpl_fire;

  assign commit      = valid_q[head_q] & done_q[head_q];
  assign commit_xcpt = commit & xcpt_q[head_q];
  assign commit_ok   = commit & ~xcpt_q[head_q];

  assign alloc_ready = (count_q != FULL_CNT) && !commit_xcpt;
  assign alloc_id    = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  // Completions landing in the flush cycle would target entries about to be discarded.
  assign cmpl_fire   = cmpl_valid && valid_q[cmpl_id] && !commit_xcpt;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (cmpl_fire) done_d[cmpl_id] = 1'b1;
    if (commit) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + ROB_ID_WIDTH'(1);
    end
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + ROB_ID_WIDTH'(1);
    end
    case ({alloc_fire, commit_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (commit_xcpt) begin
      valid_d = '0;
      done_d  = '0;
      tail_d  = head_q + ROB_ID_WIDTH'(1);
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      pc_q[tail_q]       <= alloc_pc;
      has_dest_q[tail_q] <= alloc_has_dest;
      dest_q[tail_q]     <= alloc_dest_addr;
      iret_q[tail_q]     <= alloc_iret;
    end
    if (cmpl_fire) begin
      value_q[cmpl_id] <= cmpl_value;
      xcpt_q[cmpl_id]  <= cmpl_xcpt_valid;
      xtype_q[cmpl_id] <= cmpl_xcpt_type;
      xaddr_q[cmpl_id] <= cmpl_xcpt_addr;
    end
  end

  assign writeEn    = commit_ok & has_dest_q[head_q];
  assign dest_addr  = writeEn ? dest_q[head_q] : '0;
  assign writeVal   = writeEn ? value_q[head_q] : '0;
  assign iret_instr = commit_ok & iret_q[head_q];
  assign xcpt_valid = commit_xcpt;
  assign xcpt_type  = commit_xcpt ? xtype_q[head_q] : '0;
  assign rmPC       = commit_xcpt ? pc_q[head_q] : '0;
  assign rmAddr     = commit_xcpt ? xaddr_q[head_q] : '0;
  assign flush      = commit_xcpt;
  assign empty      = (count_q == '0);

endmodule
